// File: rtl/stump_sequencer_pkg.sv
// Stump control-path definitions shared by the sequencer slice:
// state encodings, opcode field values and flag bit positions.
package stump_sequencer_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'b00,
      EXECUTE = 2'b01,
      MEMORY  = 2'b10
   } state_t;

   localparam logic [2:0] ADD  = 3'b000;
   localparam logic [2:0] ADC  = 3'b001;
   localparam logic [2:0] SUB  = 3'b010;
   localparam logic [2:0] SBC  = 3'b011;
   localparam logic [2:0] AND  = 3'b100;
   localparam logic [2:0] OR   = 3'b101;
   localparam logic [2:0] LDST = 3'b110;
   localparam logic [2:0] BCC  = 3'b111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   // Only ALU-class opcodes with the S bit may touch the flags.
   function automatic logic may_set_cc(input logic [15:0] instr);
      return instr[11] && (instr[15:13] != BCC) && (instr[15:13] != LDST);
   endfunction

endpackage

// File: rtl/stump_ccr.sv
// Stump condition-code register {N,Z,V,C} with gated write enable.
module stump_ccr (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] d,
   output logic [3:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         q <= 4'h0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/stump_sequencer.sv
// Stump sequencer: FSM state, IR, CC, halt/resume and a
// retired-instruction counter feeding the control decoder.
module stump_sequencer
   import stump_sequencer_pkg::*;
#(
   parameter int          CNT_W    = 16,
   parameter logic [15:0] IR_RESET = 16'h0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_ready,
   input  logic [15:0]      mem_rdata,
   input  logic             cc_en,
   input  logic [3:0]       flags_in,
   input  logic             halt_req,
   output logic [1:0]       state,
   output logic [15:0]      ir,
   output logic [3:0]       cc,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   state_t state_q;
   logic   cc_we;

   assign state = state_q;
   assign cc_we = (state_q == EXECUTE) && cc_en && may_set_cc(ir);

   stump_ccr u_ccr (
      .clk (clk),
      .rst (rst),
      .en  (cc_we),
      .d   (flags_in),
      .q   (cc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FETCH;
         ir          <= IR_RESET;
         halted      <= 1'b0;
         instr_count <= '0;
      end else begin
         case (state_q)
            FETCH: begin
               if (halted) begin
                  halted <= halt_req;
               end else if (mem_ready) begin
                  ir      <= mem_rdata;
                  state_q <= EXECUTE;
               end else begin
                  halted <= halt_req;
               end
            end
            EXECUTE: begin
               if (ir[15:13] == LDST) begin
                  state_q <= MEMORY;
               end else begin
                  state_q     <= FETCH;
                  instr_count <= instr_count + CNT_W'(1);
                  halted      <= halt_req;
               end
            end
            MEMORY: begin
               if (mem_ready) begin
                  state_q     <= FETCH;
                  instr_count <= instr_count + CNT_W'(1);
                  halted      <= halt_req;
               end
            end
            // 2'b11 is unreachable; recover without retiring.
            default: state_q <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_stump_sequencer.sv
// Directed bench for stump_sequencer: reset, ALU/LDST/branch
// flows, halt/resume, async reset and 4-bit counter wrap.
module tb_stump_sequencer;

   localparam int          CW  = 4;
   localparam logic [15:0] IRR = 16'hC0DE;
   localparam logic [1:0]  S_F = 2'b00;
   localparam logic [1:0]  S_E = 2'b01;
   localparam logic [1:0]  S_M = 2'b10;

   logic          clk;
   logic          rst;
   logic          mem_ready;
   logic [15:0]   mem_rdata;
   logic          cc_en;
   logic [3:0]    flags_in;
   logic          halt_req;
   logic [1:0]    state;
   logic [15:0]   ir;
   logic [3:0]    cc;
   logic          halted;
   logic [CW-1:0] instr_count;

   int tests_run;
   int tests_failed;

   stump_sequencer #(
      .CNT_W    (CW),
      .IR_RESET (IRR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .cc_en       (cc_en),
      .flags_in    (flags_in),
      .halt_req    (halt_req),
      .state       (state),
      .ir          (ir),
      .cc          (cc),
      .halted      (halted),
      .instr_count (instr_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      mem_rdata = 16'h0000;
      cc_en = 1'b0;
      flags_in = 4'h0;
      halt_req = 1'b0;
      #2 rst = 1'b0;
      #1;
      tick();
      tests_run++;
      if (state !== S_F) begin
         $display("FAIL reset_state got=%0h exp=%0h", state, S_F);
         tests_failed++;
      end
      tests_run++;
      if (ir !== IRR) begin
         $display("FAIL reset_ir got=%h exp=%h", ir, IRR);
         tests_failed++;
      end
      tests_run++;
      if (cc !== 4'h0 || halted !== 1'b0 || instr_count !== 4'h0) begin
         $display("FAIL reset_regs got cc=%h h=%b n=%h exp 0/0/0",
                  cc, halted, instr_count);
         tests_failed++;
      end
      rst = 1'b1;
   endtask

   task automatic test_add();
      mem_rdata = 16'h0A40;
      mem_ready = 1'b1;
      cc_en = 1'b1;
      flags_in = 4'b0100;
      tick();
      tests_run++;
      if (state !== S_E || ir !== 16'h0A40) begin
         $display("FAIL add_fetch got st=%0h ir=%h exp st=1 ir=0a40",
                  state, ir);
         tests_failed++;
      end
      mem_ready = 1'b0;
      tick();
      tests_run++;
      if (state !== S_F || cc !== 4'b0100 || instr_count !== 4'd1) begin
         $display("FAIL add_retire got st=%0h cc=%h n=%0d exp 0/4/1",
                  state, cc, instr_count);
         tests_failed++;
      end
   endtask

   task automatic test_ldst();
      mem_rdata = 16'hC800;
      flags_in = 4'b1111;
      cc_en = 1'b1;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (state !== S_M || cc !== 4'b0100 || instr_count !== 4'd1) begin
            $display("FAIL ldst_wait%0d got st=%0h cc=%h n=%0d exp 2/4/1",
                     i, state, cc, instr_count);
            tests_failed++;
         end
         if (i == 2) mem_ready = 1'b1;
         tick();
      end
      mem_ready = 1'b0;
      tests_run++;
      if (state !== S_F || instr_count !== 4'd2 || cc !== 4'b0100) begin
         $display("FAIL ldst_exit got st=%0h n=%0d cc=%h exp 0/2/4",
                  state, instr_count, cc);
         tests_failed++;
      end
   endtask

   task automatic test_branch();
      #1 rst = 1'b0;
      #1 rst = 1'b1;
      mem_rdata = 16'hE800;
      flags_in = 4'hF;
      cc_en = 1'b1;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tests_run++;
      if (state !== S_E || ir !== 16'hE800) begin
         $display("FAIL bcc_fetch got st=%0h ir=%h exp 1/e800", state, ir);
         tests_failed++;
      end
      tick();
      tests_run++;
      if (state !== S_F || cc !== 4'h0 || instr_count !== 4'd1) begin
         $display("FAIL bcc_retire got st=%0h cc=%h n=%0d exp 0/0/1",
                  state, cc, instr_count);
         tests_failed++;
      end
   endtask

   task automatic test_halt();
      mem_rdata = 16'h0A40;
      flags_in = 4'b0001;
      cc_en = 1'b1;
      mem_ready = 1'b1;
      tick();
      halt_req = 1'b1;
      mem_rdata = 16'h2000;
      tick();
      tests_run++;
      if (state !== S_F || halted !== 1'b1 || instr_count !== 4'd2 ||
          cc !== 4'b0001) begin
         $display("FAIL halt_enter got st=%0h h=%b n=%0d cc=%h exp 0/1/2/1",
                  state, halted, instr_count, cc);
         tests_failed++;
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         tests_run++;
         if (state !== S_F || halted !== 1'b1 || ir !== 16'h0A40 ||
             instr_count !== 4'd2) begin
            $display("FAIL halt_park%0d got st=%0h h=%b ir=%h n=%0d",
                     i, state, halted, ir, instr_count);
            tests_failed++;
         end
      end
      halt_req = 1'b0;
      tick();
      tests_run++;
      if (halted !== 1'b0 || state !== S_F || ir !== 16'h0A40) begin
         $display("FAIL halt_release got h=%b st=%0h ir=%h exp 0/0/0a40",
                  halted, state, ir);
         tests_failed++;
      end
      tick();
      tests_run++;
      if (state !== S_E || ir !== 16'h2000) begin
         $display("FAIL halt_resume got st=%0h ir=%h exp 1/2000", state, ir);
         tests_failed++;
      end
      mem_ready = 1'b0;
      tick();
      tests_run++;
      if (state !== S_F || instr_count !== 4'd3 || cc !== 4'b0001) begin
         $display("FAIL resume_retire got st=%0h n=%0d cc=%h exp 0/3/1",
                  state, instr_count, cc);
         tests_failed++;
      end
   endtask

   task automatic test_fetch_vs_halt();
      mem_rdata = 16'h0000;
      mem_ready = 1'b1;
      halt_req = 1'b1;
      tick();
      mem_ready = 1'b0;
      tests_run++;
      if (state !== S_E || halted !== 1'b0 || ir !== 16'h0000) begin
         $display("FAIL fetch_wins got st=%0h h=%b ir=%h exp 1/0/0000",
                  state, halted, ir);
         tests_failed++;
      end
      tick();
      tests_run++;
      if (state !== S_F || halted !== 1'b1 || instr_count !== 4'd4) begin
         $display("FAIL halt_boundary got st=%0h h=%b n=%0d exp 0/1/4",
                  state, halted, instr_count);
         tests_failed++;
      end
      halt_req = 1'b0;
      tick();
      halt_req = 1'b1;
      tick();
      tests_run++;
      if (halted !== 1'b1 || state !== S_F) begin
         $display("FAIL halt_in_wait got h=%b st=%0h exp 1/0", halted, state);
         tests_failed++;
      end
      halt_req = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      mem_rdata = 16'hC000;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tests_run++;
      if (state !== S_M) begin
         $display("FAIL areset_pre got st=%0h exp 2", state);
         tests_failed++;
      end
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (state !== S_F || ir !== IRR || cc !== 4'h0 ||
          instr_count !== 4'h0 || halted !== 1'b0) begin
         $display("FAIL areset got st=%0h ir=%h cc=%h n=%0d h=%b",
                  state, ir, cc, instr_count, halted);
         tests_failed++;
      end
      #1 rst = 1'b1;
   endtask

   task automatic test_wrap();
      mem_rdata = 16'h0000;
      cc_en = 1'b0;
      mem_ready = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) begin
         tick();
         tick();
      end
      tests_run++;
      if (state !== S_E || instr_count !== 4'hF) begin
         $display("FAIL wrap_max got st=%0h n=%h exp 1/f",
                  state, instr_count);
         tests_failed++;
      end
      mem_ready = 1'b0;
      tick();
      tests_run++;
      if (state !== S_F || instr_count !== 4'h0) begin
         $display("FAIL wrap_zero got st=%0h n=%h exp 0/0",
                  state, instr_count);
         tests_failed++;
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_add();
      test_ldst();
      test_branch();
      test_halt();
      test_fetch_vs_halt();
      test_async_reset();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
